demux_1bit_sync: RTL and testbench

- Registered 1-input, N-output single-bit demultiplexer.
- The data bit `x` is steered to the output selected by `sel`. Every non-selected output is driven to the idle value (0).
- Default configuration is 1-to-2: `y[0]` = x when sel=0, `y[1]` = x when sel=1.
- Sits in control/steering paths where one serial bit fans out to one of several consumers. Outputs are registered for clean timing.

---
 rtl/demux_pkg.sv | 10 +
 rtl/demux_1bit_sync.sv | 41 ++++
 tb/tb_demux_1bit_sync.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the single-bit registered demultiplexer.
package demux_pkg;

    localparam logic DEMUX_IDLE = 1'b0;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n_out);
        return (sel < n_out);
    endfunction

endpackage

// File: rtl/demux_1bit_sync.sv
// Registered 1-to-N single-bit demultiplexer with a sticky out-of-range select flag.
module demux_1bit_sync
    import demux_pkg::*;
#(
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned SEL_W      = $clog2(N_OUT),
    parameter bit          HOLD_UNSEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] y,
    output logic [SEL_W-1:0] sel_q,
    output logic             sel_err
);

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= {N_OUT{DEMUX_IDLE}};
            sel_q   <= '0;
            sel_err <= 1'b0;
        end else if (en) begin
            sel_q <= sel;
            if (sel_in_range(32'(sel), N_OUT)) begin
                for (int unsigned i = 0; i < N_OUT; i++) begin
                    if (i == 32'(sel))
                        y[i] <= x;
                    else if (!HOLD_UNSEL)
                        y[i] <= DEMUX_IDLE;
                end
            end else begin
                // Out-of-range select clears every output even in hold mode.
                y       <= {N_OUT{DEMUX_IDLE}};
                sel_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1bit_sync.sv
// Directed self-checking bench covering 1-to-2, 1-to-4 (hold mode) and 1-to-3 configurations.
module tb_demux_1bit_sync;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en2, x2;
    logic [0:0] sel2, selq2;
    logic [1:0] y2;
    logic       err2;

    logic       en4, x4;
    logic [1:0] sel4, selq4;
    logic [3:0] y4;
    logic       err4;

    logic       en3, x3;
    logic [1:0] sel3, selq3;
    logic [2:0] y3;
    logic       err3;

    int unsigned passed = 0;
    int unsigned total  = 0;

    demux_1bit_sync #(.N_OUT(2), .HOLD_UNSEL(1'b0)) d2 (
        .clk(clk), .rst(rst), .en(en2), .x(x2), .sel(sel2),
        .y(y2), .sel_q(selq2), .sel_err(err2)
    );

    demux_1bit_sync #(.N_OUT(4), .HOLD_UNSEL(1'b1)) d4 (
        .clk(clk), .rst(rst), .en(en4), .x(x4), .sel(sel4),
        .y(y4), .sel_q(selq4), .sel_err(err4)
    );

    demux_1bit_sync #(.N_OUT(3), .HOLD_UNSEL(1'b0)) d3 (
        .clk(clk), .rst(rst), .en(en3), .x(x3), .sel(sel3),
        .y(y3), .sel_q(selq3), .sel_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Sample 1 time unit after the rising edge; inputs change here too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic xv, input logic sv, input logic [1:0] ey, input string tag);
        x2 = xv; sel2 = sv;
        tick();
        chk(tag, 32'(y2), 32'(ey));
        chk({tag, "_selq"}, 32'(selq2), 32'(sv));
    endtask

    task automatic step4(input logic xv, input logic [1:0] sv, input logic [3:0] ey, input string tag);
        x4 = xv; sel4 = sv;
        tick();
        chk(tag, 32'(y4), 32'(ey));
        chk({tag, "_selq"}, 32'(selq4), 32'(sv));
    endtask

    initial begin
        rst = 1'b1;
        en2 = 1'b1; x2 = 1'b1; sel2 = 1'b1;
        en4 = 1'b1; x4 = 1'b1; sel4 = 2'd1;
        en3 = 1'b1; x3 = 1'b1; sel3 = 2'd3;
        tick();
        tick();
        chk("rst_y2",    32'(y2),    32'h0);
        chk("rst_selq2", 32'(selq2), 32'h0);
        chk("rst_err2",  32'(err2),  32'h0);
        chk("rst_y4",    32'(y4),    32'h0);
        chk("rst_y3",    32'(y3),    32'h0);
        chk("rst_err3",  32'(err3),  32'h0);

        rst = 1'b0;
        en4 = 1'b0; en3 = 1'b0;

        step2(1'b1, 1'b0, 2'b01, "route_a");
        step2(1'b0, 1'b1, 2'b00, "route_b");
        step2(1'b1, 1'b1, 2'b10, "route_c");
        step2(1'b0, 1'b0, 2'b00, "route_d");
        step2(1'b1, 1'b1, 2'b10, "route_e");

        en2 = 1'b0; x2 = 1'b0; sel2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_y2",    32'(y2),    32'h2);
            chk("hold_selq2", 32'(selq2), 32'h1);
        end
        en2 = 1'b1;
        tick();
        chk("resume_y2",    32'(y2),    32'h0);
        chk("resume_selq2", 32'(selq2), 32'h0);
        en2 = 1'b0;

        en4 = 1'b1;
        step4(1'b1, 2'd0, 4'b0001, "hold_a");
        step4(1'b1, 2'd2, 4'b0101, "hold_b");
        step4(1'b0, 2'd0, 4'b0100, "hold_c");
        step4(1'b1, 2'd3, 4'b1100, "hold_d");
        chk("hold_err4", 32'(err4), 32'h0);
        en4 = 1'b0;

        en3 = 1'b1; x3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("oor_y3",    32'(y3),    32'h0);
        chk("oor_err3",  32'(err3),  32'h1);
        chk("oor_selq3", 32'(selq3), 32'h3);
        sel3 = 2'd1;
        tick();
        chk("legal_y3",   32'(y3),   32'h2);
        chk("sticky_err", 32'(err3), 32'h1);
        en3 = 1'b0; sel3 = 2'd0; x3 = 1'b0;
        tick();
        chk("en0_y3",   32'(y3),   32'h2);
        chk("en0_err3", 32'(err3), 32'h1);
        rst = 1'b1;
        tick();
        chk("clr_err3", 32'(err3), 32'h0);
        chk("clr_y3",   32'(y3),   32'h0);
        chk("clr_y4",   32'(y4),   32'h0);
        rst = 1'b0;

        en2 = 1'b1;
        step2(1'b1, 1'b1, 2'b10, "mid_pre");
        rst = 1'b1; x2 = 1'b1; sel2 = 1'b1;
        tick();
        chk("mid_rst_y2",    32'(y2),    32'h0);
        chk("mid_rst_selq2", 32'(selq2), 32'h0);
        rst = 1'b0;
        step2(1'b1, 1'b0, 2'b01, "mid_resume");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
